// File: rtl/piano_pkg.sv
// Shared definitions for the piano polyphony scheduler: size defaults,
// FSM state encodings and the lowest-set-bit helper used by voice_pick.
package piano_pkg;

  localparam int DEF_NUM_KEYS   = 32;
  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_KEY_W      = 5;
  localparam int DEF_AGE_W      = 8;

  localparam int VIDX_W = (DEF_NUM_VOICES > 1) ? $clog2(DEF_NUM_VOICES) : 1;

  // Allocator FSM states, kept as plain constants for legacy tooling.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_ASSIGN  = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Index of the lowest set bit; returns 0 when no bit is set.
  function automatic logic [VIDX_W-1:0] lowest_set(input logic [DEF_NUM_VOICES-1:0] vec);
    lowest_set = '0;
    for (int i = DEF_NUM_VOICES - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = VIDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Bus between the keypad scanner (master) and the voice allocator (slave),
// which also carries the per-voice results to the tone generators.
interface voice_allocator_if
  import piano_pkg::*;
#(
  parameter int NUM_KEYS   = DEF_NUM_KEYS,
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int KEY_W      = DEF_KEY_W
);

  logic                        scan_valid;
  logic [NUM_KEYS-1:0]         keyPressed;
  logic [NUM_VOICES-1:0]       voice_active;
  logic [NUM_VOICES*KEY_W-1:0] voice_key;
  logic [NUM_VOICES-1:0]       voice_start;
  logic [NUM_VOICES-1:0]       voice_stop;
  logic                        busy;
  logic                        done;

  modport master (
    output scan_valid, keyPressed,
    input  voice_active, voice_key, voice_start, voice_stop, busy, done
  );

  modport slave (
    input  scan_valid, keyPressed,
    output voice_active, voice_key, voice_start, voice_stop, busy, done
  );

endinterface

// File: rtl/voice_allocator_voice_pick.sv
// Combinational voice selection: lowest-index free voice and, when the
// VOICE_STEAL_EN macro is defined, the oldest voice (ties to lowest index).
module voice_pick
  import piano_pkg::*;
(
  input  logic [DEF_NUM_VOICES-1:0]           active,
`ifdef VOICE_STEAL_EN
  input  logic [DEF_NUM_VOICES*DEF_AGE_W-1:0] ages,
  output logic [VIDX_W-1:0]                   old_idx,
`endif
  output logic                                free_any,
  output logic [VIDX_W-1:0]                   free_idx
);

  // Free voices are the inactive ones; priority goes to the lowest index.
  always_comb begin
    free_any = ~&active;
    free_idx = lowest_set(~active);
  end

`ifdef VOICE_STEAL_EN
  // Scan upward with a strict compare so equal ages keep the lower index.
  always_comb begin
    logic [DEF_AGE_W-1:0] best;
    old_idx = '0;
    best    = ages[0 +: DEF_AGE_W];
    for (int v = 1; v < DEF_NUM_VOICES; v++) begin
      if (ages[v*DEF_AGE_W +: DEF_AGE_W] > best) begin
        best    = ages[v*DEF_AGE_W +: DEF_AGE_W];
        old_idx = VIDX_W'(v);
      end
    end
  end
`endif

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: on each key scan it frees voices whose key went up,
// then hands free voices to newly pressed keys in ascending key order.
// Optional feature macro: VOICE_STEAL_EN (steal the oldest voice when full).
module voice_allocator
  import piano_pkg::*;
#(
  parameter int NUM_KEYS   = DEF_NUM_KEYS,
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int KEY_W      = DEF_KEY_W
`ifdef VOICE_STEAL_EN
  , parameter int AGE_W    = DEF_AGE_W
`endif
)
(
  input  logic              CLOCK_50,
  input  logic              reset,
  voice_allocator_if.slave  bus
);

  localparam logic [KEY_W-1:0]  LAST_KEY   = KEY_W'(NUM_KEYS - 1);
  localparam logic [VIDX_W-1:0] LAST_VOICE = VIDX_W'(NUM_VOICES - 1);

  logic [1:0]            state;
  logic [NUM_KEYS-1:0]   snap;
  logic [NUM_KEYS-1:0]   hold;
  logic                  pending;
  logic [VIDX_W-1:0]     vidx;
  logic [KEY_W-1:0]      kidx;
  logic [NUM_VOICES-1:0] active_q;
  logic [NUM_VOICES-1:0] start_q;
  logic [NUM_VOICES-1:0] stop_q;
  logic [KEY_W-1:0]      key_q [NUM_VOICES];
  logic                  busy_q;
  logic                  done_q;
  logic                  key_held;
  logic                  free_any;
  logic [VIDX_W-1:0]     free_idx;
  logic [NUM_VOICES*KEY_W-1:0] key_flat;

`ifdef VOICE_STEAL_EN
  logic [AGE_W-1:0]            age_q [NUM_VOICES];
  logic [NUM_VOICES*AGE_W-1:0] age_flat;
  logic [VIDX_W-1:0]           old_idx;

  // Flatten ages for the selector.
  always_comb begin
    age_flat = '0;
    for (int v = 0; v < NUM_VOICES; v++) age_flat[v*AGE_W +: AGE_W] = age_q[v];
  end
`endif

  voice_pick u_pick (
    .active   (active_q),
`ifdef VOICE_STEAL_EN
    .ages     (age_flat),
    .old_idx  (old_idx),
`endif
    .free_any (free_any),
    .free_idx (free_idx)
  );

  // A key already sounding on some active voice keeps that voice.
  always_comb begin
    key_held = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (active_q[v] && key_q[v] == kidx) key_held = 1'b1;
    end
  end

  // Pack per-voice key registers onto the output bus.
  always_comb begin
    key_flat = '0;
    for (int v = 0; v < NUM_VOICES; v++) key_flat[v*KEY_W +: KEY_W] = key_q[v];
  end

  assign bus.voice_active = active_q;
  assign bus.voice_key    = key_flat;
  assign bus.voice_start  = start_q;
  assign bus.voice_stop   = stop_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

  // Allocation FSM: capture, release pass, assign pass, wrap-up.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= ST_IDLE;
      snap     <= '0;
      hold     <= '0;
      pending  <= 1'b0;
      vidx     <= '0;
      kidx     <= '0;
      active_q <= '0;
      start_q  <= '0;
      stop_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      // NOTE: the key table is reset, unlike a plain storage array, because
      // it drives voice_key directly and every output must read 0 after reset.
      for (int v = 0; v < NUM_VOICES; v++) key_q[v] <= '0;
`ifdef VOICE_STEAL_EN
      for (int v = 0; v < NUM_VOICES; v++) age_q[v] <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; the pulse defaults below
      // are overridden later in the same block when a pulse is due.
      start_q <= '0;
      stop_q  <= '0;
      done_q  <= 1'b0;

      if (bus.scan_valid && (state == ST_RELEASE || state == ST_ASSIGN)) begin
        hold    <= bus.keyPressed;
        pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (bus.scan_valid) begin
            snap   <= bus.keyPressed;
            vidx   <= '0;
            busy_q <= 1'b1;
            state  <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (active_q[vidx] && !snap[key_q[vidx]]) begin
            active_q[vidx] <= 1'b0;
            stop_q[vidx]   <= 1'b1;
          end
          if (vidx == LAST_VOICE) begin
            kidx  <= '0;
            state <= ST_ASSIGN;
          end else begin
            vidx <= vidx + 1'b1;
          end
        end

        ST_ASSIGN: begin
          if (snap[kidx] && !key_held) begin
            if (free_any) begin
              key_q[free_idx]    <= kidx;
              active_q[free_idx] <= 1'b1;
              start_q[free_idx]  <= 1'b1;
`ifdef VOICE_STEAL_EN
              age_q[free_idx]    <= '0;
            end else begin
              key_q[old_idx]   <= kidx;
              start_q[old_idx] <= 1'b1;
              stop_q[old_idx]  <= 1'b1;
              age_q[old_idx]   <= '0;
`endif
            end
          end
          if (kidx == LAST_KEY) state <= ST_DONE;
          else                  kidx  <= kidx + 1'b1;
        end

        default: begin  // ST_DONE
          done_q <= 1'b1;
`ifdef VOICE_STEAL_EN
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (active_q[v] && age_q[v] != '1) age_q[v] <= age_q[v] + 1'b1;
          end
`endif
          // A scan arriving right now is the newest one and wins over the held copy.
          if (bus.scan_valid) begin
            snap    <= bus.keyPressed;
            pending <= 1'b0;
            vidx    <= '0;
            state   <= ST_RELEASE;
          end else if (pending) begin
            snap    <= hold;
            pending <= 1'b0;
            vidx    <= '0;
            state   <= ST_RELEASE;
          end else begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with hand-computed expectations.
// Covers both builds of the VOICE_STEAL_EN macro.
module tb_voice_allocator;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #10 clk = ~clk;

  voice_allocator_if bus ();

  voice_allocator dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.scan_valid = 1'b0;
    bus.keyPressed = '0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  // One complete pass: returns edges from the capture edge (inclusive) to
  // the done pulse, plus every start/stop pulse seen and voices pulsed both ways at once.
  task automatic run_pass(input logic [31:0] keys, output int lat,
                          output logic [3:0] st, output logic [3:0] sp, output logic [3:0] both);
    bus.keyPressed = keys;
    bus.scan_valid = 1'b1;
    step();
    bus.scan_valid = 1'b0;
    lat  = 1;
    st   = '0;
    sp   = '0;
    both = '0;
    while (!bus.done && lat < 200) begin
      st   |= bus.voice_start;
      sp   |= bus.voice_stop;
      both |= bus.voice_start & bus.voice_stop;
      step();
      lat++;
    end
  endtask

  initial begin
    int         lat;
    int         n;
    int         first_done;
    int         second_done;
    int         pulses;
    logic       busy_at_first;
    logic [3:0] st, sp, both;

    // Reset state
    do_reset();
    check("rst_active", 32'(bus.voice_active), 32'h0);
    check("rst_key",    32'(bus.voice_key),    32'h0);
    check("rst_busy",   32'(bus.busy),         32'h0);
    check("rst_pulses", 32'({bus.voice_start, bus.voice_stop, bus.done}), 32'h0);

    // Keys 0 and 2 pressed
    run_pass(32'h5, lat, st, sp, both);
    check("p1_latency", 32'(lat),              32'd38);
    check("p1_start",   32'(st),               32'h3);
    check("p1_stop",    32'(sp),               32'h0);
    check("p1_active",  32'(bus.voice_active), 32'h3);
    check("p1_key",     32'(bus.voice_key),    32'h40);
    check("p1_busy",    32'(bus.busy),         32'h0);
    step();
    check("p1_done_pulse", 32'(bus.done), 32'h0);

    // Key 0 released: voice 0 stops, voice 1 keeps key 2 untouched
    run_pass(32'h4, lat, st, sp, both);
    check("p2_stop",   32'(sp),                 32'h1);
    check("p2_start",  32'(st),                 32'h0);
    check("p2_active", 32'(bus.voice_active),   32'h2);
    check("p2_v1key",  32'(bus.voice_key[9:5]), 32'd2);
    step();

`ifdef VOICE_STEAL_EN
    // Full pool, equal ages: key 4 steals voice 0
    do_reset();
    run_pass(32'h0F, lat, st, sp, both);
    check("s1_active", 32'(bus.voice_active), 32'hF);
    step();
    run_pass(32'h1F, lat, st, sp, both);
    check("s2_start",  32'(st),               32'h1);
    check("s2_stop",   32'(sp),               32'h1);
    check("s2_both",   32'(both),             32'h1);
    check("s2_key",    32'(bus.voice_key),    32'h18824);
    check("s2_active", 32'(bus.voice_active), 32'hF);
    step();
`else
    // Five keys, four voices: key 4 is dropped
    do_reset();
    run_pass(32'h1F, lat, st, sp, both);
    check("d1_start",  32'(st),               32'hF);
    check("d1_active", 32'(bus.voice_active), 32'hF);
    check("d1_key",    32'(bus.voice_key),    32'h18820);
    step();
    // Key 1 released: voice 1 freed and handed to key 4
    run_pass(32'h1D, lat, st, sp, both);
    check("d2_stop",   32'(sp),               32'h2);
    check("d2_start",  32'(st),               32'h2);
    check("d2_key",    32'(bus.voice_key),    32'h18880);
    check("d2_active", 32'(bus.voice_active), 32'hF);
    step();
`endif

    // Two scans during a pass: newest (0x2) drives a back-to-back second pass
    do_reset();
    bus.keyPressed = 32'h8;
    bus.scan_valid = 1'b1;
    step();
    n             = 1;
    first_done    = 0;
    second_done   = 0;
    busy_at_first = 1'b0;
    sp            = '0;
    while (n < 200 && second_done == 0) begin
      if (n == 5) begin
        bus.scan_valid = 1'b1;
        bus.keyPressed = 32'h1;
      end else if (n == 10) begin
        bus.scan_valid = 1'b1;
        bus.keyPressed = 32'h2;
      end else begin
        bus.scan_valid = 1'b0;
      end
      step();
      n++;
      if (first_done != 0) sp |= bus.voice_stop;
      if (bus.done) begin
        if (first_done == 0) begin
          first_done    = n;
          busy_at_first = bus.busy;
        end else begin
          second_done = n;
        end
      end
    end
    bus.scan_valid = 1'b0;
    check("pend_first_done", 32'(first_done),          32'd38);
    check("pend_busy_held",  32'(busy_at_first),       32'h1);
    check("pend_gap",        32'(second_done - first_done), 32'd37);
    check("pend_stop",       32'(sp),                  32'h1);
    check("pend_active",     32'(bus.voice_active),    32'h1);
    check("pend_key",        32'(bus.voice_key),       32'h1);
    check("pend_busy_end",   32'(bus.busy),            32'h0);
    step();

    // Reset during ASSIGN
    do_reset();
    bus.keyPressed = 32'h5;
    bus.scan_valid = 1'b1;
    step();
    bus.scan_valid = 1'b0;
    repeat (9) step();
    check("mid_active_before", 32'(bus.voice_active), 32'h3);
    reset = 1'b1;
    step();
    check("mid_active", 32'(bus.voice_active), 32'h0);
    check("mid_busy",   32'(bus.busy),         32'h0);
    check("mid_pulses", 32'({bus.voice_start, bus.voice_stop, bus.done}), 32'h0);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (bus.done || bus.busy || (|bus.voice_start) || (|bus.voice_stop)) pulses++;
    end
    check("mid_no_resume", 32'(pulses), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
